wb_daq_bus_arbiter: RTL and testbench
=====================================

WB_DAQ_BUS_ARBITER -- requirements
Module: wb_daq_bus_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- dw, 32, data width.
- aw, 8, address width.
- TIMEOUT, 16, cycles before the watchdog error fires (range 2..255).
REQ-002 wb_clk  in  1  single clock; all logic on its rising edge.
REQ-003 wb_rst  in  1  reset, synchronous, active-high.
REQ-004 mN_adr_i, mN_dat_i, mN_sel_i, mN_we_i, mN_cyc_i, mN_stb_i  in  aw/dw/4/1/1/1  master N request (N = 0, 1).
REQ-005 mN_dat_o, mN_ack_o, mN_err_o, mN_rty_o  out  dw/1/1/1  master N response.
REQ-006 s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o  out  aw/dw/4/1/1/1  shared slave request (DAQ slave register bank).
REQ-007 s_dat_i, s_ack_i, s_err_i, s_rty_i  in  dw/1/1/1  shared slave response.
REQ-008 grant  out  2  one-hot current owner; 2'b00 when idle.

Function
REQ-009 FSM states SHALL be IDLE, GNT0 and GNT1, registered on wb_clk.
REQ-010 IDLE -> GNTn SHALL occur on the edge where mN_cyc_i is sampled high; grant is visible the following cycle.
REQ-011 Simultaneous m0/m1 requests in IDLE SHALL be resolved round-robin: grant the master not served last; last_owner resets to 1, so m0 wins first.
REQ-012 GNTn SHALL hold while mN_cyc_i=1 and SHALL return to IDLE on the edge where mN_cyc_i=0, giving a minimum one-cycle idle gap between owners.
REQ-013 Slave request outputs SHALL be a combinational mux of the granted master's signals.
REQ-014 s_cyc_o and s_stb_o SHALL be 0 in IDLE.
REQ-015 Slave ack/err/rty SHALL route only to the granted master; the other master's response strobes SHALL be 0.
REQ-016 mN_dat_o SHALL carry s_dat_i for both masters.
REQ-017 A non-granted master's request SHALL be ignored (no side effects) until it is granted.
REQ-018 No pipelining: a grant adds zero cycles to slave ack latency once held.
REQ-019 Deasserting mN_cyc_i mid-transfer SHALL release the grant; a late slave ack arriving in IDLE SHALL be discarded.

Reset
REQ-020 On wb_rst=1 the FSM SHALL enter IDLE, grant=0, last_owner=1 and the timeout counter SHALL clear.
REQ-021 During reset and one cycle after, all s_* request strobes and all mN_ack_o/err_o/rty_o SHALL be 0.
REQ-022 Reset asserted mid-transfer SHALL abort the transfer with no response to the master.

Configuration
REQ-023 Macro WB_DAQ_ARB_TIMEOUT_EN SHALL control the watchdog.
- Defined: an 8-bit counter SHALL increment each cycle s_stb_o=1 and ack/err/rty are all 0, and SHALL clear on any response or grant change.
- On reaching TIMEOUT the arbiter SHALL pulse mN_err_o for exactly one cycle to the owner, force s_stb_o=0 that cycle, and clear the counter.
- Undefined: no counter or logic exists, and mN_err_o equals the routed s_err_i only.

Structure
REQ-024 A shared package SHALL hold the state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and the TIMEOUT default.
REQ-025 The watchdog SHALL be one sub-module, wb_daq_arb_watchdog (inputs: clk, rst, active, done; output: expire).
- It is instantiated only under WB_DAQ_ARB_TIMEOUT_EN.

Verification
REQ-026 Reset release, m0 writes 32'hDEADBEEF, sel=4'hF, adr=0, slave acks next cycle -> grant=2'b01, s_dat_o=DEADBEEF, m0_ack_o one cycle, m1 responses 0.
REQ-027 m0 and m1 raise cyc on the same cycle, repeated 3 times -> grants in order m0, m1, m0, with one IDLE cycle between each.
REQ-028 m1 holds cyc for a 4-beat burst while m0 requests -> m0 not granted until m1 drops cyc; m0_ack_o stays 0 throughout.
REQ-029 With WB_DAQ_ARB_TIMEOUT_EN and TIMEOUT=16, slave never acks -> m0_err_o pulses exactly 16 cycles after stb; without the macro, no err ever appears.
REQ-030 wb_rst asserted on the cycle m1 is granted with stb high -> next cycle grant=0, s_stb_o=0, no ack to m1; after release, m0 is favored first.

Source files
------------

// File: rtl/wb_daq_bus_arbiter_pkg.sv
// Shared types for the two-master Wishbone arbiter in front of the DAQ register bank.
// State encoding, response bundle and watchdog defaults live here.
package wb_daq_bus_arbiter_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 16;
  localparam int unsigned SEL_W           = 4;
  localparam int unsigned CNT_W           = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic ack;
    logic err;
    logic rty;
  } wb_rsp_t;

  // One-hot owner vector for a given arbiter state
  function automatic logic [1:0] grant_of(input arb_state_e s);
    case (s)
      GNT0:    return 2'b01;
      GNT1:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_daq_bus_arbiter_if.sv
// Bus bundle between two Wishbone masters, the arbiter and the shared DAQ slave.
// slave modport is the arbiter's view; master modport is the surrounding system's view.
interface wb_daq_bus_arbiter_if
  import wb_daq_bus_arbiter_pkg::*;
#(
  parameter int unsigned dw = 32,
  parameter int unsigned aw = 8
);

  logic [aw-1:0]    m0_adr_i, m1_adr_i;
  logic [dw-1:0]    m0_dat_i, m1_dat_i;
  logic [SEL_W-1:0] m0_sel_i, m1_sel_i;
  logic             m0_we_i,  m1_we_i;
  logic             m0_cyc_i, m1_cyc_i;
  logic             m0_stb_i, m1_stb_i;

  logic [dw-1:0]    m0_dat_o, m1_dat_o;
  logic             m0_ack_o, m1_ack_o;
  logic             m0_err_o, m1_err_o;
  logic             m0_rty_o, m1_rty_o;

  logic [aw-1:0]    s_adr_o;
  logic [dw-1:0]    s_dat_o;
  logic [SEL_W-1:0] s_sel_o;
  logic             s_we_o, s_cyc_o, s_stb_o;

  logic [dw-1:0]    s_dat_i;
  logic             s_ack_i, s_err_i, s_rty_i;

  logic [1:0]       grant;

  modport slave (
    input  m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
    input  m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
    output m0_dat_o, m0_ack_o, m0_err_o, m0_rty_o,
    output m1_dat_o, m1_ack_o, m1_err_o, m1_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output grant
  );

  modport master (
    output m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
    output m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
    input  m0_dat_o, m0_ack_o, m0_err_o, m0_rty_o,
    input  m1_dat_o, m1_ack_o, m1_err_o, m1_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  grant
  );

endinterface

// File: rtl/wb_daq_bus_arbiter_watchdog.sv
// Stalled-strobe watchdog: counts unanswered strobe cycles and pulses expire for one
// cycle when the count reaches TIMEOUT. Only instantiated under WB_DAQ_ARB_TIMEOUT_EN.
module wb_daq_arb_watchdog
  import wb_daq_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic done,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  // Expiry clears the count so a still-stalled slave restarts a full window
  always_comb begin
    cnt_d = cnt_q;
    if (done || expire_q) begin
      cnt_d = '0;
    end else if (active) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expire_d = (cnt_d == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire = expire_q;

endmodule

// File: rtl/wb_daq_bus_arbiter.sv
// Round-robin arbiter giving two Wishbone masters exclusive access to the DAQ slave.
// Optional stalled-slave watchdog enabled by defining WB_DAQ_ARB_TIMEOUT_EN.
module wb_daq_bus_arbiter
  import wb_daq_bus_arbiter_pkg::*;
#(
  parameter int unsigned dw      = 32,
  parameter int unsigned aw      = 8,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic                 wb_clk,
  input logic                 wb_rst,
  wb_daq_bus_arbiter_if.slave bus
);

  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("wb_daq_bus_arbiter: TIMEOUT must lie in 2..255");
  end

  arb_state_e       state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic [1:0]       grant_q, grant_d;
  logic             own0, own1;
  logic             expire;
  wb_rsp_t          rsp;
  logic             any_rsp;

  logic [aw-1:0]    adr_c;
  logic [dw-1:0]    dat_c;
  logic [SEL_W-1:0] sel_c;
  logic             we_c, cyc_c, stb_c;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      grant_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
    end
  end

  // Tie between requesters goes to whoever was not served last
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (bus.m0_cyc_i && (!bus.m1_cyc_i || last_owner_q)) begin
          state_d      = GNT0;
          last_owner_d = 1'b0;
        end else if (bus.m1_cyc_i) begin
          state_d      = GNT1;
          last_owner_d = 1'b1;
        end
      end
      GNT0:    if (!bus.m0_cyc_i) state_d = IDLE;
      GNT1:    if (!bus.m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    grant_d = grant_of(state_d);
  end

  // Ownership is squashed while reset is high so nothing leaks before the flops clear
  assign own0 = (state_q == GNT0) && !wb_rst;
  assign own1 = (state_q == GNT1) && !wb_rst;

  always_comb begin
    adr_c = bus.m0_adr_i;
    dat_c = bus.m0_dat_i;
    sel_c = bus.m0_sel_i;
    we_c  = bus.m0_we_i;
    cyc_c = 1'b0;
    stb_c = 1'b0;
    if (own1) begin
      adr_c = bus.m1_adr_i;
      dat_c = bus.m1_dat_i;
      sel_c = bus.m1_sel_i;
      we_c  = bus.m1_we_i;
      cyc_c = bus.m1_cyc_i;
      stb_c = bus.m1_stb_i;
    end else if (own0) begin
      cyc_c = bus.m0_cyc_i;
      stb_c = bus.m0_stb_i;
    end
  end

  always_comb begin
    rsp.ack = bus.s_ack_i;
    rsp.err = bus.s_err_i;
    rsp.rty = bus.s_rty_i;
  end

  assign any_rsp = rsp.ack | rsp.err | rsp.rty;

`ifdef WB_DAQ_ARB_TIMEOUT_EN
  logic wd_active, wd_done;

  assign wd_active = stb_c & ~any_rsp;
  assign wd_done   = any_rsp | (grant_d != grant_q);

  wb_daq_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (wb_clk),
    .rst    (wb_rst),
    .active (wd_active),
    .done   (wd_done),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign bus.s_adr_o = adr_c;
  assign bus.s_dat_o = dat_c;
  assign bus.s_sel_o = sel_c;
  assign bus.s_we_o  = we_c;
  assign bus.s_cyc_o = cyc_c;
  assign bus.s_stb_o = stb_c & ~expire;

  // Responses reach only the owner; a late ack landing in IDLE is dropped
  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;
  assign bus.m0_ack_o = own0 & rsp.ack;
  assign bus.m1_ack_o = own1 & rsp.ack;
  assign bus.m0_err_o = own0 & (rsp.err | expire);
  assign bus.m1_err_o = own1 & (rsp.err | expire);
  assign bus.m0_rty_o = own0 & rsp.rty;
  assign bus.m1_rty_o = own1 & rsp.rty;
  assign bus.grant    = grant_q;

  // any_rsp is only consumed by the watchdog; keep it referenced in every build
  logic unused_ok;
  assign unused_ok = any_rsp;

endmodule

// File: tb/tb_wb_daq_bus_arbiter.sv
// Directed bench for wb_daq_bus_arbiter: reset, single write, round-robin ties,
// burst hold-off, watchdog (WB_DAQ_ARB_TIMEOUT_EN aware) and mid-grant reset.
module tb_wb_daq_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  wb_daq_bus_arbiter_if #(.dw(32), .aw(8)) bus ();

  wb_daq_bus_arbiter #(
    .dw      (32),
    .aw      (8),
    .TIMEOUT (16)
  ) dut (
    .wb_clk (clk),
    .wb_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.m0_adr_i = '0; bus.m0_dat_i = '0; bus.m0_sel_i = '0;
    bus.m0_we_i = 1'b0; bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
    bus.m1_adr_i = '0; bus.m1_dat_i = '0; bus.m1_sel_i = '0;
    bus.m1_we_i = 1'b0; bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0;
    bus.s_dat_i = '0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_m0(input logic on);
    bus.m0_cyc_i = on;
    bus.m0_stb_i = on;
  endtask

  task automatic set_m1(input logic on);
    bus.m1_cyc_i = on;
    bus.m1_stb_i = on;
  endtask

  logic [1:0] rr_exp [3];
  logic       exp_err;

  initial begin
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;
    clear_inputs();
    rst = 1'b1;

    // Reset held: no strobes, no grant, even with a master asking
    set_m0(1'b1);
    tick(); tick();
    mid();
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_stb",   32'(bus.s_stb_o), 32'h0);
    check("rst_cyc",   32'(bus.s_cyc_o), 32'h0);

    // Single m0 write after release
    tick();
    rst = 1'b0;
    bus.m0_adr_i = 8'h00; bus.m0_dat_i = 32'hDEADBEEF; bus.m0_sel_i = 4'hF; bus.m0_we_i = 1'b1;
    mid();
    check("post_rst_grant", 32'(bus.grant), 32'h0);
    check("post_rst_stb",   32'(bus.s_stb_o), 32'h0);
    check("post_rst_ack",   32'(bus.m0_ack_o), 32'h0);
    tick();
    mid();
    check("wr_grant", 32'(bus.grant), 32'h1);
    check("wr_stb",   32'(bus.s_stb_o), 32'h1);
    check("wr_dat",   bus.s_dat_o, 32'hDEADBEEF);
    check("wr_sel",   32'(bus.s_sel_o), 32'hF);
    check("wr_adr",   32'(bus.s_adr_o), 32'h0);
    check("wr_we",    32'(bus.s_we_o), 32'h1);
    tick();
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h12345678;
    mid();
    check("wr_m0_ack", 32'(bus.m0_ack_o), 32'h1);
    check("wr_m1_ack", 32'(bus.m1_ack_o), 32'h0);
    check("wr_m1_err", 32'(bus.m1_err_o), 32'h0);
    check("wr_m0_dat", bus.m0_dat_o, 32'h12345678);
    check("wr_m1_dat", bus.m1_dat_o, 32'h12345678);
    tick();
    bus.s_ack_i = 1'b0;
    set_m0(1'b0);
    mid();
    check("wr_ack_drop", 32'(bus.m0_ack_o), 32'h0);
    check("wr_hold",     32'(bus.grant), 32'h1);
    check("wr_cyc_drop", 32'(bus.s_cyc_o), 32'h0);
    tick();
    mid();
    check("wr_idle", 32'(bus.grant), 32'h0);

    // Round robin on simultaneous requests, starting fresh from reset
    do_reset();
    for (int r = 0; r < 3; r++) begin
      tick();
      set_m0(1'b1); set_m1(1'b1); bus.s_ack_i = 1'b0;
      mid();
      check($sformatf("rr%0d_idle", r), 32'(bus.grant), 32'h0);
      tick();
      bus.s_ack_i = 1'b1;
      mid();
      check($sformatf("rr%0d_grant", r), 32'(bus.grant), 32'(rr_exp[r]));
      check($sformatf("rr%0d_m0_ack", r), 32'(bus.m0_ack_o), 32'(rr_exp[r][0]));
      check($sformatf("rr%0d_m1_ack", r), 32'(bus.m1_ack_o), 32'(rr_exp[r][1]));
      tick();
      set_m0(1'b0); set_m1(1'b0); bus.s_ack_i = 1'b0;
      mid();
      check($sformatf("rr%0d_hold", r), 32'(bus.grant), 32'(rr_exp[r]));
    end
    tick();
    mid();
    check("rr_end_idle", 32'(bus.grant), 32'h0);

    // m1 burst holds off m0
    bus.m0_adr_i = 8'h10; bus.m1_adr_i = 8'h40; bus.m1_dat_i = 32'hCAFE0001;
    set_m1(1'b1);
    tick();
    set_m0(1'b1);
    for (int b = 0; b < 4; b++) begin
      bus.s_ack_i = 1'b1;
      mid();
      check($sformatf("burst%0d_grant", b), 32'(bus.grant), 32'h2);
      check($sformatf("burst%0d_adr", b), 32'(bus.s_adr_o), 32'h40);
      check($sformatf("burst%0d_m1_ack", b), 32'(bus.m1_ack_o), 32'h1);
      check($sformatf("burst%0d_m0_ack", b), 32'(bus.m0_ack_o), 32'h0);
      tick();
    end
    set_m1(1'b0);
    bus.s_ack_i = 1'b0;
    mid();
    check("burst_drop_grant", 32'(bus.grant), 32'h2);
    check("burst_drop_m0_ack", 32'(bus.m0_ack_o), 32'h0);
    tick();
    bus.s_ack_i = 1'b1;
    mid();
    check("late_ack_grant", 32'(bus.grant), 32'h0);
    check("late_ack_m0", 32'(bus.m0_ack_o), 32'h0);
    check("late_ack_m1", 32'(bus.m1_ack_o), 32'h0);
    tick();
    bus.s_ack_i = 1'b0;
    mid();
    check("burst_m0_grant", 32'(bus.grant), 32'h1);
    check("burst_m0_adr", 32'(bus.s_adr_o), 32'h10);
    tick();
    set_m0(1'b0);
    tick();

    // Slave never answers: watchdog error exactly 16 cycles into the strobe
    set_m0(1'b1);
    for (int k = 0; k < 18; k++) begin
      tick();
      mid();
`ifdef WB_DAQ_ARB_TIMEOUT_EN
      exp_err = (k == 16);
`else
      exp_err = 1'b0;
`endif
      check($sformatf("wd%0d_err", k), 32'(bus.m0_err_o), 32'(exp_err));
      check($sformatf("wd%0d_stb", k), 32'(bus.s_stb_o), 32'(!exp_err));
    end
    tick();
    set_m0(1'b0);
    tick();
    tick();

    // Reset while m1 owns the bus with strobe high
    set_m1(1'b1);
    mid();
    check("mrst_pre_grant", 32'(bus.grant), 32'h0);
    tick();
    rst = 1'b1;
    bus.s_ack_i = 1'b1;
    mid();
    check("mrst_stb", 32'(bus.s_stb_o), 32'h0);
    check("mrst_m1_ack", 32'(bus.m1_ack_o), 32'h0);
    tick();
    rst = 1'b0;
    set_m0(1'b1);
    mid();
    check("mrst_after_grant", 32'(bus.grant), 32'h0);
    check("mrst_after_stb", 32'(bus.s_stb_o), 32'h0);
    check("mrst_after_m1_ack", 32'(bus.m1_ack_o), 32'h0);
    tick();
    mid();
    check("mrst_m0_first", 32'(bus.grant), 32'h1);
    check("mrst_m0_ack", 32'(bus.m0_ack_o), 32'h1);
    check("mrst_m1_ack_ng", 32'(bus.m1_ack_o), 32'h0);
    tick();
    clear_inputs();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
